// File: rtl/fnd_pkg.sv
// Shared constants and helpers for the 4-digit common-anode FND display stage.
package fnd_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef logic [1:0] digit_idx_t;

  localparam logic MODE_SEC_MSEC = 1'b0;
  localparam logic MODE_HOUR_MIN = 1'b1;

  localparam int DP_BIT = 7;

  // Two decimal digits are all the display can show, so larger values saturate.
  function automatic logic [6:0] clamp99(input logic [6:0] v);
    return (v > 7'd99) ? 7'd99 : v;
  endfunction

  function automatic logic [3:0] tensOf(input logic [6:0] v);
    return 4'(v / 7'd10);
  endfunction

  function automatic logic [3:0] onesOf(input logic [6:0] v);
    return 4'(v % 7'd10);
  endfunction

endpackage

// File: rtl/fnd_decoder.sv
// Combinational BCD digit + decimal point to active-low segment pattern.
module fnd_decoder
  import fnd_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_dp_on,
  output logic [7:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_digit)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
    // An invalid digit stays fully dark, decimal point included.
    if (i_dp_on && (i_digit <= 4'd9)) o_seg[DP_BIT] = 1'b0;
  end

endmodule

// File: rtl/fnd_controller.sv
// Time-multiplexed scanner for a 4-digit FND showing sec.msec or hour.min.
module fnd_controller
  import fnd_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int SCAN_HZ     = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_mode,
  input  logic [6:0] i_msec,
  input  logic [5:0] i_sec,
  input  logic [5:0] i_min,
  input  logic [4:0] i_hour,
  output logic [3:0] o_fnd_com,
  output logic [7:0] o_fnd_data
);

  // DIV must be at least 2 for the slot counter to be meaningful.
  localparam int DIV   = CLK_FREQ_HZ / SCAN_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] r_div_cnt;
  digit_idx_t       r_idx;
  logic             r_mode;

  logic       w_tick;
  logic [6:0] w_low;
  logic [6:0] w_high;
  logic [3:0] w_digit;
  logic       w_dp_on;
  logic [7:0] w_seg;

  assign w_tick = (r_div_cnt == CNT_W'(DIV - 1));

  assign w_low  = clamp99((r_mode == MODE_HOUR_MIN) ? {1'b0, i_min}  : i_msec);
  assign w_high = clamp99((r_mode == MODE_HOUR_MIN) ? {2'b00, i_hour} : {1'b0, i_sec});

  always_comb begin
    w_digit = 4'd0;
    case (r_idx)
      2'd0: w_digit = onesOf(w_low);
      2'd1: w_digit = tensOf(w_low);
      2'd2: w_digit = onesOf(w_high);
      2'd3: w_digit = tensOf(w_high);
      default: w_digit = 4'd0;
    endcase
  end

  // Separator sits left of digit 2; it blinks at 1 Hz only in hour.min mode.
  assign w_dp_on = (r_idx == 2'd2) &&
                   ((r_mode == MODE_SEC_MSEC) || (i_msec < 7'd50));

  fnd_decoder u_decoder (
    .i_digit (w_digit),
    .i_dp_on (w_dp_on),
    .o_seg   (w_seg)
  );

  // Mode is only taken at the frame boundary so a frame never mixes fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt  <= '0;
      r_idx      <= 2'd0;
      r_mode     <= MODE_SEC_MSEC;
      o_fnd_com  <= 4'b1111;
      o_fnd_data <= SEG_BLANK;
    end else begin
      r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
      if (w_tick) r_idx <= r_idx + 2'd1;
      if (w_tick && (r_idx == 2'd3)) r_mode <= i_mode;
      o_fnd_com  <= ~(4'b0001 << r_idx);
      o_fnd_data <= w_seg;
    end
  end

endmodule

// File: tb/tb_fnd_controller.sv
// Self-checking bench for fnd_controller with DIV=4 (16-cycle frames).
module tb_fnd_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_mode;
  logic [6:0] i_msec;
  logic [5:0] i_sec;
  logic [5:0] i_min;
  logic [4:0] i_hour;
  logic [3:0] o_fnd_com;
  logic [7:0] o_fnd_data;

  fnd_controller #(
    .CLK_FREQ_HZ (1000),
    .SCAN_HZ     (250)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_mode     (i_mode),
    .i_msec     (i_msec),
    .i_sec      (i_sec),
    .i_min      (i_min),
    .i_hour     (i_hour),
    .o_fnd_com  (o_fnd_com),
    .o_fnd_data (o_fnd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       mode;
    logic [6:0] msec;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [7:0] d3;
  } vec_t;

  typedef struct {
    string      name;
    logic [3:0] com;
    logic [7:0] data;
  } exp_t;

  localparam int NV = 9;
  vec_t vecs[NV];
  exp_t sbq[$];
  int   nVectors = 0;
  int   nMiscompares = 0;
  int   cyc = 0;

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic stepTo(input int target);
    while (cyc < target) step();
  endtask

  task automatic pushExpect(input string name, input logic [3:0] com, input logic [7:0] data);
    exp_t e;
    e.name = name;
    e.com  = com;
    e.data = data;
    sbq.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    nVectors++;
    if (sbq.size() == 0) begin
      nMiscompares++;
      $display("[TB] FAIL scoreboard_empty: com=%b data=%h, no expectation queued", o_fnd_com, o_fnd_data);
    end else begin
      e = sbq.pop_front();
      if ((o_fnd_com !== e.com) || (o_fnd_data !== e.data)) begin
        nMiscompares++;
        $display("[TB] FAIL %s: got com=%b data=%h, expected com=%b data=%h",
                 e.name, o_fnd_com, o_fnd_data, e.com, e.data);
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    i_mode = v.mode;
    i_msec = v.msec;
    i_sec  = v.sec;
    i_min  = v.min;
    i_hour = v.hour;
  endtask

  initial begin
    logic [7:0] frame0[4];
    logic [3:0] expCom;

    vecs[0] = '{1'b0, 7'd5,   6'd37, 6'd12, 5'd7,  8'h92, 8'hC0, 8'h78, 8'hB0};
    vecs[1] = '{1'b1, 7'd10,  6'd37, 6'd59, 5'd23, 8'h90, 8'h92, 8'h30, 8'hA4};
    vecs[2] = '{1'b1, 7'd60,  6'd37, 6'd59, 5'd23, 8'h90, 8'h92, 8'hB0, 8'hA4};
    vecs[3] = '{1'b0, 7'd120, 6'd55, 6'd12, 5'd7,  8'h90, 8'h90, 8'h12, 8'h92};
    vecs[4] = '{1'b1, 7'd49,  6'd11, 6'd0,  5'd0,  8'hC0, 8'hC0, 8'h40, 8'hC0};
    vecs[5] = '{1'b1, 7'd50,  6'd11, 6'd8,  5'd16, 8'h80, 8'hC0, 8'h82, 8'hF9};
    vecs[6] = '{1'b0, 7'd99,  6'd0,  6'd33, 5'd9,  8'h90, 8'h90, 8'h40, 8'hC0};
    vecs[7] = '{1'b1, 7'd127, 6'd22, 6'd63, 5'd31, 8'hB0, 8'h82, 8'hF9, 8'hB0};
    vecs[8] = '{1'b0, 7'd100, 6'd42, 6'd1,  5'd1,  8'h90, 8'h90, 8'h24, 8'h99};

    // Reset with i_mode=1 applied: the first frame must still show sec.msec.
    rst = 1'b1;
    i_mode = 1'b1; i_msec = 7'd5; i_sec = 6'd37; i_min = 6'd59; i_hour = 5'd23;
    for (int i = 0; i < 3; i++) begin
      step();
      pushExpect("reset_hold", 4'b1111, 8'hFF);
      checkOutput();
    end
    rst = 1'b0;
    cyc = 0;

    frame0[0] = 8'h92; frame0[1] = 8'hC0; frame0[2] = 8'h78; frame0[3] = 8'hB0;
    for (int c = 1; c <= 16; c++) begin
      step();
      expCom = ~(4'b0001 << ((c - 1) / 4));
      pushExpect("scan_frame0", expCom, frame0[(c - 1) / 4]);
      checkOutput();
    end
    step();
    pushExpect("frame1_mode_latched", 4'b1110, 8'h90);
    checkOutput();

    for (int i = 0; i < NV; i++) begin
      int f;
      f = 2 + i;
      stepTo(16 * f - 1);
      applyStimulus(vecs[i]);
      pushExpect($sformatf("vec%0d_idx0", i), 4'b1110, vecs[i].d0);
      pushExpect($sformatf("vec%0d_idx1", i), 4'b1101, vecs[i].d1);
      pushExpect($sformatf("vec%0d_idx2", i), 4'b1011, vecs[i].d2);
      pushExpect($sformatf("vec%0d_idx3", i), 4'b0111, vecs[i].d3);
      for (int k = 0; k < 4; k++) begin
        stepTo(16 * f + 4 * k + 2);
        checkOutput();
      end
    end

    // Mode raised during idx1 must not affect the rest of the current frame.
    begin
      int fm;
      fm = 2 + NV;
      stepTo(16 * fm - 1);
      i_mode = 1'b0; i_msec = 7'd5; i_sec = 6'd37; i_min = 6'd59; i_hour = 5'd23;
      pushExpect("modechg_idx0", 4'b1110, 8'h92);
      pushExpect("modechg_idx1", 4'b1101, 8'hC0);
      stepTo(16 * fm + 2);  checkOutput();
      stepTo(16 * fm + 6);  checkOutput();
      i_mode = 1'b1;
      pushExpect("modechg_idx2_old", 4'b1011, 8'h78);
      pushExpect("modechg_idx3_old", 4'b0111, 8'hB0);
      pushExpect("modechg_next_idx0", 4'b1110, 8'h90);
      pushExpect("modechg_next_idx2", 4'b1011, 8'h30);
      stepTo(16 * fm + 10); checkOutput();
      stepTo(16 * fm + 14); checkOutput();
      stepTo(16 * fm + 18); checkOutput();
      stepTo(16 * fm + 26); checkOutput();

      // One-cycle reset during idx2 restarts the scan from a full idx0 slot.
      stepTo(16 * (fm + 2) + 9);
      rst = 1'b1;
      step();
      pushExpect("midreset", 4'b1111, 8'hFF);
      checkOutput();
      rst = 1'b0;
      cyc = 0;
      for (int c = 1; c <= 5; c++) begin
        step();
        if (c <= 4) pushExpect("postreset_idx0", 4'b1110, 8'h92);
        else        pushExpect("postreset_idx1", 4'b1101, 8'hC0);
        checkOutput();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, time=%0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
